frame_scan_ctrl: RTL
====================

Name: frame_scan_ctrl

Overview:
- Sequences the pixel clock divider for the display path: gates the divider with `div_enable` and consumes its single-cycle `pixel_tick` strobe.
- Walks column and row counters through active, horizontal-blank and vertical-blank periods.
- Drives `hsync`/`vsync` and pulls pixels from an upstream source via a valid/ready handshake.
- Provides start/abort/busy/done control to the top-level FSM.

Parameters:
- H_ACTIVE, 8, pixels per line (>=2)
- V_ACTIVE, 8, lines per frame (>=2)
- H_BLANK, 2, ticks of horizontal blank per line (>=1)
- V_BLANK, 4, ticks of vertical blank per frame (>=1)
- COL_W, 4, width of col output; must hold H_ACTIVE-1
- ROW_W, 4, width of row output; must hold V_ACTIVE-1

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- start  input  1  begin a frame (level sampled each cycle)
- abort  input  1  terminate immediately
- continuous  input  1  restart automatically after frame end
- pixel_tick  input  1  one-cycle strobe from clock divider
- div_enable  output  1  enable to clock divider
- pix_valid  input  1  upstream pixel available
- pix_ready  output  1  pixel consumed this cycle
- col  output  COL_W  current column
- row  output  ROW_W  current row
- hsync  output  1  high during HBLANK
- vsync  output  1  high during VBLANK
- busy  output  1  state != IDLE
- frame_done  output  1  one-cycle pulse at frame end
- underrun  output  1  one-cycle pulse, pixel missing at tick

Behaviour:
- Reset values: state IDLE; all outputs 0; col, row and blank counter 0.
- Output timing: all outputs registered except `pix_ready`.
  - pix_ready = (state==ACTIVE) & pixel_tick & pix_valid, combinational.
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE:
  - div_enable=0; pixel_tick ignored.
  - start=1 -> ACTIVE next cycle with col=row=0 and div_enable=1, busy=1 (1-cycle latency).
- ACTIVE, on pixel_tick:
  - pix_valid=0: underrun=1 the following cycle; the column still advances (blank pixel).
  - col<H_ACTIVE-1: col+1.
  - col==H_ACTIVE-1: -> HBLANK, blank counter=0, hsync=1.
- HBLANK, on pixel_tick:
  - Blank counter increments.
  - After the H_BLANK-th tick: hsync=0, col=0.
  - If row==V_ACTIVE-1: -> VBLANK, row=0, vsync=1. Else row+1 -> ACTIVE.
- VBLANK, on pixel_tick:
  - Count V_BLANK ticks.
  - On the last tick: vsync=0, frame_done=1 for exactly one cycle.
  - Next state: continuous=1 (sampled that cycle) -> ACTIVE; else -> IDLE with div_enable=0.
- Tick counts: each frame is exactly (H_ACTIVE+H_BLANK)*V_ACTIVE+V_BLANK ticks.
- Ignored inputs:
  - start while busy is ignored.
  - Ticks never advance more than one step per cycle.
- abort:
  - From any state -> IDLE next cycle; counters cleared; hsync/vsync/div_enable=0.
  - No frame_done pulse; abort on the same cycle as the last VBLANK tick suppresses frame_done.
  - start and abort in the same cycle: abort wins.
- Reset mid-frame: immediate return to reset values; no pulses.
- Counter wrap: col and row never wrap beyond their ACTIVE limits; the blank counter is sized ceil(log2(max(H_BLANK,V_BLANK)+1)).

Decomposition:
- Package `display_pkg`:
  - state enum `scan_state_t` {IDLE, ACTIVE, HBLANK, VBLANK}
  - default timing constants H_ACTIVE, V_ACTIVE, H_BLANK, V_BLANK
- Sub-module `blank_counter`: a small loadable down-counter with terminal-count output, shared by HBLANK and VBLANK. Everything else stays flat.

Test Plan:
Common setup: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, V_BLANK=3; divider model ticks every 4 cycles.
1. Reset values: assert n_rst=0 mid-frame, release -> all outputs 0, state IDLE, div_enable=0 within the same cycle as the reset assertion.
2. Single frame: start pulse with continuous=0, pix_valid=1 always -> div_enable rises the next cycle.
   - Col sequence 0,1,2,3 then hsync high for 2 ticks; row 0 then 1.
   - vsync high for 3 ticks.
   - frame_done pulses once after the 15th tick.
   - Exactly 8 pix_ready pulses; then IDLE, div_enable=0.
3. Underrun: pix_valid=0 at the tick for row 0 col 2 -> underrun pulses once; col still reaches 3; 7 pix_ready pulses total.
4. Continuous: continuous=1 -> second frame starts ACTIVE with col=row=0 immediately after frame_done; busy never drops between frames.
5. Abort: abort during HBLANK of row 0 -> IDLE next cycle, hsync=0, no frame_done.
   - Simultaneous start+abort in IDLE -> stays IDLE.
6. Start while busy: extra start pulses mid-frame -> no change to counters or frame length (still 15 ticks).

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared scan state encoding and default display timing
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } scan_state_t;

  localparam int unsigned H_ACTIVE_DEF = 8;
  localparam int unsigned V_ACTIVE_DEF = 8;
  localparam int unsigned H_BLANK_DEF  = 2;
  localparam int unsigned V_BLANK_DEF  = 4;

  // One counter serves both blank periods, so it must hold the longer one.
  function automatic int unsigned blank_width(input int unsigned h_blank,
                                               input int unsigned v_blank);
    int unsigned longest;
    longest = (h_blank > v_blank) ? h_blank : v_blank;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/blank_counter.sv
// rtl/blank_counter.sv - loadable down-counter with terminal count for blank periods
module blank_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/frame_scan_ctrl.sv
// rtl/frame_scan_ctrl.sv - raster scan sequencer: divider gating, col/row walk, syncs, pixel pull
module frame_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned H_BLANK  = H_BLANK_DEF,
  parameter int unsigned V_BLANK  = V_BLANK_DEF,
  parameter int unsigned COL_W    = 4,
  parameter int unsigned ROW_W    = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  input  logic             pixel_tick,
  output logic             div_enable,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             hsync,
  output logic             vsync,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun
);

  localparam int unsigned BLANK_W = blank_width(H_BLANK, V_BLANK);
  localparam logic [COL_W-1:0]   COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(V_ACTIVE - 1);
  // The counter exits on terminal count, so N ticks means loading N-1.
  localparam logic [BLANK_W-1:0] HB_LOAD  = BLANK_W'(H_BLANK - 1);
  localparam logic [BLANK_W-1:0] VB_LOAD  = BLANK_W'(V_BLANK - 1);

  scan_state_t      state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             busy_q, busy_d;
  logic             div_enable_q, div_enable_d;
  logic             frame_done_q, frame_done_d;
  logic             underrun_q, underrun_d;

  logic               bc_load;
  logic [BLANK_W-1:0] bc_load_val;
  logic               bc_dec;
  logic               bc_tc;

  blank_counter #(
    .W (BLANK_W)
  ) u_blank_counter (
    .clk        (clk),
    .n_rst      (n_rst),
    .clr_i      (abort),
    .load_i     (bc_load),
    .load_val_i (bc_load_val),
    .dec_i      (bc_dec),
    .tc_o       (bc_tc)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    bc_load      = 1'b0;
    bc_load_val  = '0;
    bc_dec       = 1'b0;

    if (abort) begin
      state_d = IDLE;
      col_d   = '0;
      row_d   = '0;
      hsync_d = 1'b0;
      vsync_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ACTIVE;
            col_d   = '0;
            row_d   = '0;
          end
        end

        ACTIVE: begin
          if (pixel_tick) begin
            underrun_d = ~pix_valid;
            if (col_q == COL_LAST) begin
              state_d     = HBLANK;
              hsync_d     = 1'b1;
              bc_load     = 1'b1;
              bc_load_val = HB_LOAD;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end

        HBLANK: begin
          if (pixel_tick) begin
            if (bc_tc) begin
              hsync_d = 1'b0;
              col_d   = '0;
              if (row_q == ROW_LAST) begin
                state_d     = VBLANK;
                row_d       = '0;
                vsync_d     = 1'b1;
                bc_load     = 1'b1;
                bc_load_val = VB_LOAD;
              end else begin
                state_d = ACTIVE;
                row_d   = row_q + 1'b1;
              end
            end else begin
              bc_dec = 1'b1;
            end
          end
        end

        VBLANK: begin
          if (pixel_tick) begin
            if (bc_tc) begin
              vsync_d      = 1'b0;
              frame_done_d = 1'b1;
              state_d      = continuous ? ACTIVE : IDLE;
            end else begin
              bc_dec = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d       = (state_d != IDLE);
    div_enable_d = busy_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      busy_q       <= 1'b0;
      div_enable_q <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      busy_q       <= busy_d;
      div_enable_q <= div_enable_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  // The only combinational output: the pixel is taken on the tick itself.
  assign pix_ready  = (state_q == ACTIVE) & pixel_tick & pix_valid;

  assign col        = col_q;
  assign row        = row_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign busy       = busy_q;
  assign div_enable = div_enable_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule
